// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and default geometry.
package uart_tx_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick on the wrap cycle.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter with a one-entry holding buffer so back-to-back frames leave no idle gap.
module uart_tx_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_READY,
    output logic                  busy,
    output logic                  TX_OUT,
    output logic                  frame_done
);

    localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);

    tx_state_e             state;
    logic [3:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shifter;
    logic                  par_en_r, par_bit_r, stop2_r;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_full, buf_par_en, buf_par_typ, buf_stop2;
    logic                  bit_tick, accept, last_stop, load_buf, load_in;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign TX_READY   = !buf_full;
    assign busy       = (state != ST_IDLE);
    assign accept     = Data_Valid && !buf_full;
    assign last_stop  = (state == ST_STOP) && bit_tick && (bit_idx[0] || !stop2_r);
    assign frame_done = last_stop;
    // A full buffer reloads at the last stop edge; otherwise a fresh word can start directly.
    assign load_buf   = last_stop && buf_full;
    assign load_in    = accept && ((state == ST_IDLE) || last_stop);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (busy),
        .clear    (!busy),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            buf_full <= 1'b0;
            TX_OUT   <= 1'b1;
        end else begin
            if (load_buf || load_in) begin
                state  <= ST_START;
                TX_OUT <= 1'b0;
            end else if (bit_tick) begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        TX_OUT  <= shifter[0];
                        bit_idx <= '0;
                    end
                    ST_DATA: begin
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (par_en_r) begin
                                state  <= ST_PARITY;
                                TX_OUT <= par_bit_r;
                            end else begin
                                state  <= ST_STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            TX_OUT  <= shifter[0];
                        end
                    end
                    ST_PARITY: begin
                        state   <= ST_STOP;
                        TX_OUT  <= 1'b1;
                        bit_idx <= '0;
                    end
                    ST_STOP: begin
                        if (last_stop) state <= ST_IDLE;
                        else           bit_idx <= bit_idx + 4'd1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (load_buf)
                buf_full <= 1'b0;
            else if (accept && !load_in)
                buf_full <= 1'b1;
        end
    end

    // Frame configuration is latched at load time so mid-frame input changes are ignored.
    always_ff @(posedge clk) begin
        if (load_buf) begin
            shifter   <= buf_data;
            par_en_r  <= buf_par_en;
            par_bit_r <= calc_parity(buf_data, buf_par_typ);
            stop2_r   <= buf_stop2;
        end else if (load_in) begin
            shifter   <= P_DATA;
            par_en_r  <= PAR_EN;
            par_bit_r <= calc_parity(P_DATA, PAR_TYP);
            stop2_r   <= STOP2;
        end else if (bit_tick && (state == ST_START || state == ST_DATA)) begin
            shifter <= shifter >> 1;
        end

        if (accept && !load_in) begin
            buf_data    <= P_DATA;
            buf_par_en  <= PAR_EN;
            buf_par_typ <= PAR_TYP;
            buf_stop2   <= STOP2;
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Bench for uart_tx_gen: two geometries checked cycle by cycle against a frame-queue reference model.
module tb_uart_tx_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [8:0] pd  [2];
    logic       dv  [2];
    logic       pe  [2];
    logic       pt  [2];
    logic       s2  [2];
    logic       rdy [2];
    logic       bsy [2];
    logic       txo [2];
    logic       fd  [2];

    int checks = 0;
    int errors = 0;

    // Reference model: per-cycle expected line values, {last_cycle_of_frame, line}.
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    logic [1:0] pq0 [$];
    logic [1:0] pq1 [$];
    logic [1:0] fb [$];
    logic       pend_v [2];
    logic       accd   [2];

    uart_tx_gen #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut0 (
        .clk(clk), .reset(rst), .P_DATA(pd[0][7:0]), .Data_Valid(dv[0]),
        .PAR_EN(pe[0]), .PAR_TYP(pt[0]), .STOP2(s2[0]), .TX_READY(rdy[0]),
        .busy(bsy[0]), .TX_OUT(txo[0]), .frame_done(fd[0])
    );

    uart_tx_gen #(.DATA_WIDTH(7), .CLKS_PER_BIT(4)) dut1 (
        .clk(clk), .reset(rst), .P_DATA(pd[1][6:0]), .Data_Valid(dv[1]),
        .PAR_EN(pe[1]), .PAR_TYP(pt[1]), .STOP2(s2[1]), .TX_READY(rdy[1]),
        .busy(bsy[1]), .TX_OUT(txo[1]), .frame_done(fd[1])
    );

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 7;
    endfunction

    function automatic int cpb(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %b expected %b", tag, i, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int i, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, i, obs, exp);
        end
    endtask

    // Frame = start 0, data LSB first, optional parity, 1 or 2 stop 1s; each bit CPB cycles.
    task automatic build(input int w, input int c, input logic [8:0] d,
                         input logic e, input logic t, input logic s);
        logic b [$];
        logic p;
        fb.delete();
        p = t;
        b.push_back(1'b0);
        for (int k = 0; k < w; k++) begin
            b.push_back(d[k]);
            p = p ^ d[k];
        end
        if (e) b.push_back(p);
        b.push_back(1'b1);
        if (s) b.push_back(1'b1);
        for (int j = 0; j < b.size(); j++)
            for (int k = 0; k < c; k++)
                fb.push_back({(j == b.size() - 1) && (k == c - 1), b[j]});
    endtask

    task automatic step();
        logic [1:0] hd;
        int         sz;
        logic       acc;
        for (int i = 0; i < 2; i++) begin
            sz = (i == 0) ? q0.size() : q1.size();
            hd = 2'b01;
            if (sz != 0) hd = (i == 0) ? q0[0] : q1[0];
            chk("tx_out", i, txo[i], hd[0]);
            chk("busy", i, bsy[i], sz != 0);
            chk("tx_ready", i, rdy[i], !pend_v[i]);
            chk("frame_done", i, fd[i], (sz != 0) && hd[1]);

            acc = dv[i] && !pend_v[i] && !rst;
            accd[i] = acc;
            if (rst) begin
                if (i == 0) begin q0.delete(); pq0.delete(); end
                else        begin q1.delete(); pq1.delete(); end
                pend_v[i] = 1'b0;
            end else if (i == 0) begin
                if (sz != 0) void'(q0.pop_front());
                if (q0.size() == 0 && pend_v[0]) begin q0 = pq0; pend_v[0] = 1'b0; end
                if (acc) begin
                    build(wid(0), cpb(0), pd[0], pe[0], pt[0], s2[0]);
                    if (q0.size() == 0) q0 = fb;
                    else begin pq0 = fb; pend_v[0] = 1'b1; end
                end
            end else begin
                if (sz != 0) void'(q1.pop_front());
                if (q1.size() == 0 && pend_v[1]) begin q1 = pq1; pend_v[1] = 1'b0; end
                if (acc) begin
                    build(wid(1), cpb(1), pd[1], pe[1], pt[1], s2[1]);
                    if (q1.size() == 0) q1 = fb;
                    else begin pq1 = fb; pend_v[1] = 1'b1; end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, nfd, k, guard;
        logic [8:0] words [3];

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pd[i] = '0; dv[i] = 1'b0; pe[i] = 1'b0; pt[i] = 1'b0; s2[i] = 1'b0;
            pend_v[i] = 1'b0; accd[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        step();
        rst = 1'b0;
        step();

        // 0xA5, even parity, one stop
        pd[0] = 9'h0A5; pe[0] = 1'b1; pt[0] = 1'b0; s2[0] = 1'b0; dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        n = 0; nfd = 0;
        repeat (14) begin
            if (bsy[0]) n++;
            if (fd[0]) nfd++;
            step();
        end
        chk_int("busy_cycles_a5", 0, n, 11);
        chk_int("frame_done_count_a5", 0, nfd, 1);

        // 0x00 odd parity, then 0x3C / 0xC3 back to back without parity
        pd[0] = 9'h000; pe[0] = 1'b1; pt[0] = 1'b1; dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        repeat (12) step();
        pd[0] = 9'h03C; pe[0] = 1'b0; dv[0] = 1'b1;
        step();
        pd[0] = 9'h0C3;
        step();
        dv[0] = 1'b0;
        n = 1; nfd = 0;
        repeat (24) begin
            if (bsy[0]) n++;
            if (fd[0]) nfd++;
            step();
        end
        chk_int("busy_cycles_b2b", 0, n, 20);
        chk_int("frame_done_count_b2b", 0, nfd, 2);

        // W=7, CPB=4, two stop bits, 0x55
        pd[1] = 9'h055; pe[1] = 1'b0; s2[1] = 1'b1; dv[1] = 1'b1;
        step();
        dv[1] = 1'b0;
        n = 0;
        repeat (45) begin
            if (bsy[1]) n++;
            step();
        end
        chk_int("busy_cycles_w7", 1, n, 40);

        // Three words with Data_Valid held high
        words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033;
        pe[0] = 1'b1; pt[0] = 1'b0; s2[0] = 1'b0; dv[0] = 1'b1;
        k = 0; guard = 0;
        while (k < 3 && guard < 100) begin
            pd[0] = words[k];
            step();
            if (accd[0]) k++;
            guard++;
        end
        dv[0] = 1'b0;
        chk_int("words_accepted", 0, k, 3);
        repeat (40) step();

        // Reset during data bit 3 with a word buffered
        pd[0] = 9'h0F0; pe[0] = 1'b0; dv[0] = 1'b1;
        step();
        pd[0] = 9'h00F;
        step();
        dv[0] = 1'b0;
        repeat (3) step();
        rst = 1'b1; dv[0] = 1'b1;
        step();
        rst = 1'b0; dv[0] = 1'b0;
        chk("post_reset_tx_out", 0, txo[0], 1'b1);
        chk("post_reset_busy", 0, bsy[0], 1'b0);
        chk("post_reset_ready", 0, rdy[0], 1'b1);
        repeat (20) step();

        // Random traffic with inputs changing mid-frame
        repeat (800) begin
            for (int i = 0; i < 2; i++) begin
                dv[i] = ($urandom_range(0, 3) == 0);
                pd[i] = 9'($urandom);
                pe[i] = 1'($urandom);
                pt[i] = 1'($urandom);
                s2[i] = 1'($urandom);
            end
            step();
        end
        dv[0] = 1'b0; dv[1] = 1'b0;
        repeat (120) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 1, clk cycles per serial bit; legal range 1..1024.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-006 Data_Valid  input  1  word offered; accepted on a rising edge where Data_Valid=1 and TX_READY=1.
REQ-007 PAR_EN  input  1  parity bit enabled, sampled with the word.
REQ-008 PAR_TYP  input  1  0=even, 1=odd, sampled with the word.
REQ-009 STOP2  input  1  0=one stop bit, 1=two stop bits, sampled with the word.
REQ-010 TX_READY  output  1  holding buffer free; word can be accepted.
REQ-011 busy  output  1  frame in progress (state not IDLE).
REQ-012 TX_OUT  output  1  serial line, registered, idle high.
REQ-013 frame_done  output  1  one-cycle pulse at end of last stop bit.

Function
REQ-014 Frame SHALL be: start(0), DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits(1); each bit held exactly CLKS_PER_BIT cycles.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; DATA->PARITY if PAR_EN else DATA->STOP; STOP->IDLE or STOP->START.
REQ-016 Parity SHALL be XOR of the frame's data bits for even, its inverse for odd.
REQ-017 Acceptance in IDLE SHALL load the shifter directly: TX_OUT=0 and busy=1 in the cycle after the acceptance edge.
REQ-018 Acceptance while busy SHALL store word, PAR_EN, PAR_TYP, STOP2 in a one-entry holding buffer; TX_READY=0 while it is full.
REQ-019 If the buffer is full when the last stop bit ends, the FSM SHALL go STOP->START at that edge with no idle cycle, and TX_READY SHALL return to 1 at the same edge.
REQ-020 Data_Valid with TX_READY=0 SHALL be ignored; buffered word never overwritten.
REQ-021 Configuration SHALL be fixed per frame; input changes mid-frame do not affect the current frame.
REQ-022 frame_done SHALL pulse for exactly one cycle per frame, including back-to-back frames.
REQ-023 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit index advances only on wrap.
REQ-024 Frame length SHALL be (1+DATA_WIDTH+PAR_EN+1+STOP2)*CLKS_PER_BIT cycles.

Reset
REQ-025 Reset SHALL force TX_OUT=1, busy=0, TX_READY=1, frame_done=0, state IDLE, counters 0, buffer empty.
REQ-026 Reset mid-frame SHALL abort the frame and drop any buffered word; values per REQ-025 after the reset edge.
REQ-027 Data_Valid asserted during reset SHALL not be accepted.

Structure
REQ-028 Package uart_tx_pkg SHALL hold the state enum and default DATA_WIDTH/CLKS_PER_BIT constants.
REQ-029 Bit-period counter SHALL be sub-module uart_bit_timer (enable, clear, bit_tick out); all else in uart_tx_gen.

Verification
REQ-030 W=8, CPB=1, 0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1; busy 11 cycles; one frame_done.
REQ-031 0x00, PAR_EN=1, PAR_TYP=1 -> parity bit 1; 0x3C then 0xC3 offered while busy, PAR_EN=0 -> 20 contiguous frame cycles, no idle high between frames, TX_READY low until second frame starts.
REQ-032 W=7, CPB=4, STOP2=1, PAR_EN=0, 0x55 -> 40-cycle frame, each bit 4 cycles, stop high 8 cycles.
REQ-033 Three words offered back-to-back with Data_Valid held high -> words 1 and 2 sent in order; word 3 accepted only after TX_READY returns to 1 at start of word 2's frame; no word lost or duplicated.
REQ-034 Reset asserted during data bit 3 with a buffered word -> next cycle TX_OUT=1, busy=0, TX_READY=1; buffered word never transmitted.
